// File: rtl/wb_arbiter_if.sv
// Write-back port bundle: ALU request, secondary-unit handshake and register-file write port.
interface wb_arbiter_if #(
  parameter int DSIZE = 32
);
  logic             alu_valid;
  logic [4:0]       alu_waddr;
  logic [DSIZE-1:0] alu_data;
  logic             mul_valid;
  logic             mul_ready;
  logic [4:0]       mul_waddr;
  logic [DSIZE-1:0] mul_data;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [DSIZE-1:0] rf_wdata;
  logic             stall;

  modport master (
    output alu_valid, alu_waddr, alu_data, mul_valid, mul_waddr, mul_data,
    input  mul_ready, rf_we, rf_waddr, rf_wdata, stall
  );

  modport slave (
    input  alu_valid, alu_waddr, alu_data, mul_valid, mul_waddr, mul_data,
    output mul_ready, rf_we, rf_waddr, rf_wdata, stall
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back port arbiter: ALU has fixed priority, secondary results queue in a small FIFO.
// Define WB_ARB_BYPASS_EN to let a secondary result skip the empty FIFO when the port is idle.
module wb_arbiter #(
  parameter int DSIZE      = 32,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [3:0]  STARVE_C = 4'(STARVE_MAX);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t           state, state_n;
  logic [4:0]       waddr_mem [DEPTH];
  logic [DSIZE-1:0] data_mem  [DEPTH];
  logic [AW-1:0]    wptr, rptr, wptr_n, rptr_n;
  logic [AW:0]      count, count_n;
  logic [3:0]       starve_cnt, starve_n;
  logic             vld_p1, vld_n;
  logic [4:0]       waddr_p1, waddr_n;
  logic [DSIZE-1:0] wdata_p1, wdata_n;
  logic             nonempty, xfer, push, pop, bypass;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign bus.mul_ready = !rst && (count < DEPTH_C);
  assign bus.rf_we     = vld_p1;
  assign bus.rf_waddr  = waddr_p1;
  assign bus.rf_wdata  = wdata_p1;
  assign bus.stall     = (state == DRAIN);

  always_comb begin
    nonempty = (count != '0);
    xfer     = bus.mul_valid && bus.mul_ready;
    pop      = !bus.alu_valid && nonempty;
`ifdef WB_ARB_BYPASS_EN
    bypass   = !bus.alu_valid && !nonempty && xfer;
`else
    bypass   = 1'b0;
`endif
    push     = xfer && !bypass;

    vld_n   = 1'b0;
    waddr_n = waddr_p1;
    wdata_n = wdata_p1;
    if (bus.alu_valid) begin
      vld_n   = 1'b1;
      waddr_n = bus.alu_waddr;
      wdata_n = bus.alu_data;
    end else if (pop) begin
      vld_n   = 1'b1;
      waddr_n = waddr_mem[rptr];
      wdata_n = data_mem[rptr];
    end else if (bypass) begin
      vld_n   = 1'b1;
      waddr_n = bus.mul_waddr;
      wdata_n = bus.mul_data;
    end

    wptr_n  = push ? wptr + AW'(1) : wptr;
    rptr_n  = pop  ? rptr + AW'(1) : rptr;
    count_n = count;
    if (push && !pop)      count_n = count + (AW+1)'(1);
    else if (pop && !push) count_n = count - (AW+1)'(1);

    // Counter only runs while the head is waiting behind ALU writes.
    if (pop || !nonempty)  starve_n = '0;
    else if (bus.alu_valid) starve_n = sat_inc(starve_cnt);
    else                   starve_n = starve_cnt;

    state_n = state;
    case (state)
      RUN:     if (starve_cnt >= STARVE_C && !pop) state_n = DRAIN;
      DRAIN:   if (pop) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  // Stage p1: registered write port and arbitration state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      count      <= '0;
      wptr       <= '0;
      rptr       <= '0;
      starve_cnt <= '0;
      vld_p1     <= 1'b0;
      waddr_p1   <= '0;
      wdata_p1   <= '0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      wptr       <= wptr_n;
      rptr       <= rptr_n;
      starve_cnt <= starve_n;
      vld_p1     <= vld_n;
      waddr_p1   <= waddr_n;
      wdata_p1   <= wdata_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      waddr_mem[wptr] <= bus.mul_waddr;
      data_mem[wptr]  <= bus.mul_data;
    end
  end
endmodule
